mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control sequencer for the MIPS core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the PC unit's write enable and next-PC select, the instruction-register load, the memory strobes and the register-file and ALU controls. It sits beside the datapath: it takes the opcode, funct and ALU `Zero` flag from the datapath, and a ready handshake from instruction/data memory.

## Interface
- `RESET_STATE`, default `FETCH` (4'd0): state entered on reset.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `Op` input 6: instruction bits [31:26], taken from the instruction register.
- `Funct` input 6: instruction bits [5:0].
- `Zero` input 1: ALU result == 0.
- `MemReady` input 1: memory completes the current access this cycle.
- `PCWrite` output 1: PC register load enable.
- `PCSrc` output 2: next-PC select. 00 = PC+4, 01 = branch target (ALUOut), 10 = jump {PC[31:28], idx, 2'b00}, 11 = rs (jr).
- `IRWrite` output 1: instruction register load.
- `IorD` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead` output 1, `MemWrite` output 1: memory strobes.
- `RegWrite` output 1: register-file write enable.
- `RegDst` output 2: destination register. 00 = rt, 01 = rd, 10 = $31.
- `MemtoReg` output 2: writeback source. 00 = ALUOut, 01 = MDR, 10 = PC.
- `ALUSrcA` output 1: 0 = PC, 1 = rs.
- `ALUSrcB` output 2: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp` output 3: 000 add, 001 sub, 010 funct-decoded, 011 or, 100 lui.
- `Trap` output 1: illegal opcode seen; sticky until reset.
- `State` output 4: current state, for debug.
- `InstrCnt` output 32: retired-instruction counter.

## Operation
- State register and `InstrCnt` update on posedge `CLK`. All other outputs are combinational from state, `Op`, `Funct`, `Zero` and `MemReady`.
- States: FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, MEM_ADR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, TRAP 11. Codes 12–15 go to FETCH.
- FETCH: `IorD`=0, `MemRead`=1.
  - If `MemReady`=0: stay in FETCH; `IRWrite` and `PCWrite` stay 0.
  - If `MemReady`=1: `IRWrite`=1, `PCWrite`=1, `PCSrc`=00, go to DECODE.
- DECODE: precompute the branch target with `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=add. Next state by `Op`:
  - 000000: JUMP if `Funct`=001000 (jr), else EXE_R.
  - 100011 (lw) and 101011 (sw): MEM_ADR.
  - 000100 (beq) and 000101 (bne): BRANCH.
  - 001001 (addiu), 001101 (ori), 001111 (lui): EXE_I.
  - 000010 (j) and 000011 (jal): JUMP.
  - Any other opcode: TRAP.
- EXE_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=010 → WB_ALU.
- EXE_I: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp` = add / or / lui according to `Op` → WB_ALU.
- WB_ALU: `RegWrite`=1, `MemtoReg`=00. `RegDst`=01 for R-type, 00 otherwise → FETCH.
- MEM_ADR: `ALUSrcA`=1, `ALUSrcB`=10, add → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `IorD`=1, `MemRead`=1. Hold in MEM_RD until `MemReady`=1, then → WB_MEM.
- WB_MEM: `RegWrite`=1, `RegDst`=00, `MemtoReg`=01 → FETCH.
- MEM_WR: `IorD`=1, `MemWrite`=1. Hold until `MemReady`=1, then → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, sub, `PCSrc`=01. `PCWrite` = (beq & `Zero`) | (bne & ~`Zero`) → FETCH.
- JUMP: `PCWrite`=1. `PCSrc`=11 for jr, 10 otherwise. For jal, also `RegWrite`=1, `RegDst`=10, `MemtoReg`=10; PC already holds PC+4 at this point. → FETCH.
- TRAP: `Trap`=1 and every strobe 0. Leave TRAP only on reset.
- `InstrCnt` increments by 1 on each transition into FETCH from any non-reset state. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset (`RST`=1 at a posedge):
  - State → FETCH, `InstrCnt` → 0, `Trap` → 0.
  - While `RST`=1, `PCWrite`, `IRWrite`, `MemRead`, `MemWrite` and `RegWrite` are forced to 0. The PC reset value 0x0000_3000 is applied by the PC unit.
- Reset mid-operation (any state, including memory waits): the transaction is abandoned, no strobe fires, and the next cycle is FETCH.
- Latency with `MemReady` held at 1:
  - lw: 5 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
  - Each memory wait cycle adds 1.
- `MemRead`/`MemWrite` stay asserted, and the address stays stable, until the cycle in which `MemReady`=1.
- `MemReady` asserted outside FETCH, MEM_RD and MEM_WR is ignored.

## Structure
- `signal_def.v` holds, as `define constants: state codes, opcode and funct constants, and the `PCSrc`, `ALUOp`, `RegDst` and `MemtoReg` encodings.
- One sub-module, `op_decode`, is natural. It is combinational and maps `Op`/`Funct` to an instruction class (R, I-ALU, LW, SW, BR, J, JAL, JR, ILL) and to the I-type `ALUOp`.

## Test plan
- `RST` high for 2 cycles mid-MEM_RD with `MemRead`=1 → next cycle `State`=0, all strobes 0, `InstrCnt`=0.
- Fetch with `MemReady` low for 3 cycles → `State`=0 for 3 cycles with `IRWrite`=0; `IRWrite`=`PCWrite`=1 exactly in the `MemReady` cycle.
- lw (Op=0x23), `MemReady`=1 → states 0,1,4,5,8,0; `RegWrite`=1 with `MemtoReg`=01 only in state 8; `InstrCnt` +1.
- beq with `Zero`=1 → `PCWrite`=1 and `PCSrc`=01 in state 9; beq with `Zero`=0 → `PCWrite`=0; bne with `Zero`=0 → `PCWrite`=1.
- jal (Op=0x03) → in state 10: `PCWrite`=1, `PCSrc`=10, `RegWrite`=1, `RegDst`=10, `MemtoReg`=10. jr (Op=0, Funct=0x08) → `PCSrc`=11, `RegWrite`=0.
- Op=0x3F → TRAP with `Trap`=1, held for 10 cycles with no strobes; `RST` → FETCH, `Trap`=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control sequencer.
// Holds the state codes, opcode/funct constants, instruction classes and the
// encodings of the PCSrc, ALUOp, RegDst and MemtoReg control fields.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXE_R   = 4'd2,
    EXE_I   = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WR  = 4'd6,
    WB_ALU  = 4'd7,
    WB_MEM  = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    TRAP    = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_IALU, CL_LW, CL_SW, CL_BR, CL_J, CL_JAL, CL_JR, CL_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mc_ctrl_op_decode.sv
// mc_ctrl_op_decode: combinational instruction classifier.
// Ports:
//   Op, Funct  : opcode and funct fields of the instruction register
//   Cls        : instruction class (R, I-ALU, LW, SW, BR, J, JAL, JR, ILL)
//   IAluOp     : ALU operation used by the I-type ALU execute step
module mc_ctrl_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output iclass_t    Cls,
  output logic [2:0] IAluOp
);

  always_comb begin
    Cls    = CL_ILL;
    IAluOp = ALU_ADD;
    case (Op)
      OP_RTYPE: Cls = (Funct == FN_JR) ? CL_JR : CL_R;
      OP_LW:    Cls = CL_LW;
      OP_SW:    Cls = CL_SW;
      OP_BEQ,
      OP_BNE:   Cls = CL_BR;
      OP_ADDIU: Cls = CL_IALU;
      OP_ORI: begin
        Cls    = CL_IALU;
        IAluOp = ALU_OR;
      end
      OP_LUI: begin
        Cls    = CL_IALU;
        IAluOp = ALU_LUI;
      end
      OP_J:     Cls = CL_J;
      OP_JAL:   Cls = CL_JAL;
      default:  Cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS core.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   Op, Funct, Zero     : instruction fields and ALU zero flag from the datapath
//   MemReady            : memory completes the current access this cycle
//   PCWrite, PCSrc      : PC load enable and next-PC select
//   IRWrite, IorD       : instruction register load, memory address select
//   MemRead, MemWrite   : memory strobes
//   RegWrite, RegDst,
//   MemtoReg            : register-file write controls
//   ALUSrcA, ALUSrcB,
//   ALUOp               : ALU operand/operation selects
//   Trap                : illegal opcode seen, held until reset
//   State, InstrCnt     : debug state and retired-instruction counter
//
// state   | meaning
// FETCH   | read instruction at PC, load IR and PC+4 on MemReady
// DECODE  | classify opcode, precompute branch target
// EXE_R   | R-type ALU operation
// EXE_I   | I-type ALU operation
// MEM_ADR | compute load/store address
// MEM_RD  | data read, held until MemReady
// MEM_WR  | data write, held until MemReady
// WB_ALU  | write ALU result to register file
// WB_MEM  | write loaded data to register file
// BRANCH  | compare and conditionally load branch target
// JUMP    | j / jal / jr
// TRAP    | illegal opcode, exit only on reset
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        Trap,
  output logic [3:0]  State,
  output logic [31:0] InstrCnt
);

  state_t     state, next_state;
  iclass_t    cls;
  logic [2:0] i_aluop;

  mc_ctrl_op_decode u_op_decode (
    .Op     (Op),
    .Funct  (Funct),
    .Cls    (cls),
    .IAluOp (i_aluop)
  );

  // An instruction retires whenever control returns to FETCH from elsewhere.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RESET_STATE;
      InstrCnt <= 32'd0;
    end else begin
      state <= next_state;
      if (state != FETCH && next_state == FETCH)
        InstrCnt <= InstrCnt + 32'd1;
    end
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (cls)
          CL_R:             next_state = EXE_R;
          CL_IALU:          next_state = EXE_I;
          CL_LW, CL_SW:     next_state = MEM_ADR;
          CL_BR:            next_state = BRANCH;
          CL_J, CL_JAL,
          CL_JR:            next_state = JUMP;
          default:          next_state = TRAP;
        endcase
      end
      EXE_R:   next_state = WB_ALU;
      EXE_I:   next_state = WB_ALU;
      MEM_ADR: next_state = (cls == CL_SW) ? MEM_WR : MEM_RD;
      MEM_RD:  next_state = MemReady ? WB_MEM : MEM_RD;
      MEM_WR:  next_state = MemReady ? FETCH : MEM_WR;
      WB_ALU:  next_state = FETCH;
      WB_MEM:  next_state = FETCH;
      BRANCH:  next_state = FETCH;
      JUMP:    next_state = FETCH;
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = PCSRC_PC4;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = M2R_ALU;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_ADD;
    Trap     = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE:  ALUSrcB = 2'b11;
      EXE_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      EXE_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = i_aluop;
      end
      MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      WB_ALU: begin
        RegWrite = 1'b1;
        RegDst   = (cls == CL_R) ? REGDST_RD : REGDST_RT;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PCSrc   = PCSRC_BR;
        PCWrite = (Op == OP_BNE) ? ~Zero : Zero;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = (cls == CL_JR) ? PCSRC_JR : PCSRC_J;
        // PC already holds the return address, so jal links it directly.
        if (cls == CL_JAL) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = M2R_PC;
        end
      end
      TRAP:    Trap = 1'b1;
      default: ;
    endcase
    // Abandon any in-flight transaction while reset is held.
    if (RST) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed testbench for mc_ctrl with an expected-output scoreboard.
module tb_mc_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  Op = 6'h00;
  logic [5:0]  Funct = 6'h00;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, Trap;
  logic [1:0]  PCSrc, RegDst, MemtoReg, ALUSrcB;
  logic [2:0]  ALUOp;
  logic [3:0]  State;
  logic [31:0] InstrCnt;

  mc_ctrl dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Trap(Trap), .State(State), .InstrCnt(InstrCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [22:0] ov;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [22:0] FW, FR, DEC, Z0;

  function automatic logic [22:0] v(input logic [3:0] st, input logic pcw, input logic [1:0] pcs,
                                    input logic irw, input logic iord, input logic mr, input logic mw,
                                    input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                    input logic asa, input logic [1:0] asb, input logic [2:0] aop,
                                    input logic trap);
    return {st, pcw, pcs, irw, iord, mr, mw, rw, rd, m2r, asa, asb, aop, trap};
  endfunction

  // One clock: drive inputs just after the edge, queue the expectation,
  // then compare at the falling edge.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [22:0] ev);
    exp_t e;
    logic [22:0] ov;
    @(posedge CLK);
    #1;
    RST = rst; Op = op; Funct = fn; Zero = z; MemReady = mr;
    e.tag = tag; e.ov = ev; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge CLK);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard, required one entry", tag);
    end
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ov = {State, PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst,
            MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Trap};
      checks++;
      assert (ov === e.ov) else begin
        errors++;
        $error("FAIL %s ctrl: observed=%06h expected=%06h", e.tag, ov, e.ov);
      end
      checks++;
      assert (InstrCnt === e.cnt) else begin
        errors++;
        $error("FAIL %s cnt: observed=%0d expected=%0d", e.tag, InstrCnt, e.cnt);
      end
    end
  endtask

  initial begin
    //     st   pcw pcs   irw iord mr mw rw rd    m2r   asa asb   aop     trap
    FW  = v(4'd0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0);
    FR  = v(4'd0, 1, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0);
    DEC = v(4'd1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 3'b000, 0);
    Z0  = v(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0);

    // reset, then fetch stalled for three cycles
    cyc("rst0", 1, 6'h00, 6'h00, 0, 1, Z0);
    cyc("rst1", 1, 6'h00, 6'h00, 0, 1, Z0);
    for (int i = 0; i < 3; i++) cyc("fetch_wait", 0, 6'h00, 6'h00, 0, 0, FW);
    cyc("fetch_rdy", 0, 6'h00, 6'h00, 0, 1, FR);

    // lw
    cyc("lw_dec", 0, 6'h23, 6'h00, 0, 1, DEC);
    cyc("lw_adr", 0, 6'h23, 6'h00, 0, 1, v(4'd4, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
    cyc("lw_rd",  0, 6'h23, 6'h00, 0, 1, v(4'd5, 0, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    cyc("lw_wb",  0, 6'h23, 6'h00, 0, 1, v(4'd8, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 3'b000, 0));
    exp_cnt++;

    // beq taken
    cyc("beq_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("beq_dec", 0, 6'h04, 6'h00, 1, 1, DEC);
    cyc("beq_t", 0, 6'h04, 6'h00, 1, 1, v(4'd9, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b001, 0));
    exp_cnt++;
    // beq not taken
    cyc("beq_f2", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("beq_dec2", 0, 6'h04, 6'h00, 0, 1, DEC);
    cyc("beq_nt", 0, 6'h04, 6'h00, 0, 1, v(4'd9, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b001, 0));
    exp_cnt++;
    // bne taken
    cyc("bne_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("bne_dec", 0, 6'h05, 6'h00, 0, 1, DEC);
    cyc("bne_t", 0, 6'h05, 6'h00, 0, 1, v(4'd9, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b001, 0));
    exp_cnt++;

    // jal
    cyc("jal_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("jal_dec", 0, 6'h03, 6'h00, 0, 1, DEC);
    cyc("jal_j", 0, 6'h03, 6'h00, 0, 1, v(4'd10, 1, 2'b10, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 3'b000, 0));
    exp_cnt++;
    // jr
    cyc("jr_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("jr_dec", 0, 6'h00, 6'h08, 0, 1, DEC);
    cyc("jr_j", 0, 6'h00, 6'h08, 0, 1, v(4'd10, 1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    exp_cnt++;

    // R-type addu
    cyc("r_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("r_dec", 0, 6'h00, 6'h21, 0, 1, DEC);
    cyc("r_exe", 0, 6'h00, 6'h21, 0, 1, v(4'd2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b010, 0));
    cyc("r_wb",  0, 6'h00, 6'h21, 0, 1, v(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000, 0));
    exp_cnt++;
    // addiu, ori, lui
    cyc("addiu_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("addiu_dec", 0, 6'h09, 6'h00, 0, 1, DEC);
    cyc("addiu_exe", 0, 6'h09, 6'h00, 0, 1, v(4'd3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
    cyc("addiu_wb",  0, 6'h09, 6'h00, 0, 1, v(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    exp_cnt++;
    cyc("ori_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("ori_dec", 0, 6'h0D, 6'h00, 0, 1, DEC);
    cyc("ori_exe", 0, 6'h0D, 6'h00, 0, 1, v(4'd3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b011, 0));
    cyc("ori_wb",  0, 6'h0D, 6'h00, 0, 1, v(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    exp_cnt++;
    cyc("lui_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("lui_dec", 0, 6'h0F, 6'h00, 0, 1, DEC);
    cyc("lui_exe", 0, 6'h0F, 6'h00, 0, 1, v(4'd3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b100, 0));
    cyc("lui_wb",  0, 6'h0F, 6'h00, 0, 1, v(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    exp_cnt++;

    // sw with one memory wait cycle
    cyc("sw_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("sw_dec", 0, 6'h2B, 6'h00, 0, 0, DEC);
    cyc("sw_adr", 0, 6'h2B, 6'h00, 0, 1, v(4'd4, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
    cyc("sw_wait", 0, 6'h2B, 6'h00, 0, 0, v(4'd6, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    cyc("sw_wr",   0, 6'h2B, 6'h00, 0, 1, v(4'd6, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    exp_cnt++;

    // lw abandoned by reset during MEM_RD
    cyc("lwr_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("lwr_dec", 0, 6'h23, 6'h00, 0, 1, DEC);
    cyc("lwr_adr", 0, 6'h23, 6'h00, 0, 1, v(4'd4, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0));
    cyc("lwr_rd",  0, 6'h23, 6'h00, 0, 0, v(4'd5, 0, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    cyc("lwr_rst0", 1, 6'h23, 6'h00, 0, 1, v(4'd5, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0));
    exp_cnt = 32'd0;
    cyc("lwr_rst1", 1, 6'h23, 6'h00, 0, 1, Z0);
    cyc("lwr_after", 0, 6'h00, 6'h00, 0, 0, FW);

    // illegal opcode traps until reset
    cyc("trap_f", 0, 6'h00, 6'h00, 0, 1, FR);
    cyc("trap_dec", 0, 6'h3F, 6'h00, 0, 1, DEC);
    for (int i = 0; i < 10; i++)
      cyc("trap_hold", 0, 6'h3F, 6'h00, i[1], i[0], v(4'd11, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1));
    cyc("trap_rst", 1, 6'h3F, 6'h00, 0, 1, v(4'd11, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1));
    cyc("trap_clr", 0, 6'h00, 6'h00, 0, 0, FW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
